fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch stage sitting between the combinational instruction ROM and the decode stage. It owns the fetch PC, drives the ROM address, and buffers fetched {pc, instr} pairs in a small FIFO. Decode consumes them through a valid/ready handshake. A taken branch (PCSrc) flushes the buffer and redirects fetch to branch_target.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- rom_address  output  32  byte address to ROM, equals fetch_pc register
- rom_data  input  32  ROM word at rom_address, same cycle (combinational ROM)
- PCSrc  input  1  redirect/flush request
- branch_target  input  32  new fetch PC when PCSrc=1
- instr_valid  output  1  head entry present
- instr_ready  input  1  decode accepts head this cycle
- pc  output  32  PC of head entry; 0 when instr_valid=0
- instr  output  32  instruction of head entry; 0 when instr_valid=0
- count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- pop = instr_valid & instr_ready.
- push = !PCSrc & (count < DEPTH | pop).
- Pushed entry = {fetch_pc, rom_data}.
- On push: fetch_pc <= fetch_pc + 4, with 32-bit wrap (0xFFFF_FFFC + 4 = 0).
- Otherwise fetch_pc holds.
- Priority per cycle: reset > PCSrc > push/pop.
- Reset: FIFO emptied, rd/wr pointers 0, count=0, fetch_pc=RESET_PC.
- Reset outputs: instr_valid=0, pc=0, instr=0, rom_address=RESET_PC.
- PCSrc=1: next cycle count=0, pointers 0, fetch_pc=branch_target. Any pop or push in that cycle is discarded.
- branch_target is used unmodified. Low bits are not masked.
- Full (count=DEPTH) with pop: push still occurs, count unchanged.
- Full without pop: no push, fetch_pc and rom_address frozen.
- Empty: instr_valid=0 and no pop. Push alone takes count to 1.
- Push and pop together at count ∈ [1, DEPTH]: count unchanged.
- Pointers wrap modulo DEPTH.
- count is registered and never exceeds DEPTH.
- Head outputs are driven from registered storage. There is no combinational path from rom_data to pc/instr.

## Timing
- Fetch latency 1 cycle: ROM word at rom_address in cycle N becomes head in cycle N+1 if the FIFO was empty.
- After reset deasserts in cycle 0: instr_valid=1 in cycle 1, pc=RESET_PC.
- Steady state with instr_ready=1: one instruction per cycle, PCs increasing by 4.
- Redirect penalty: PCSrc in cycle N gives instr_valid=0 in cycle N+1 and head pc=branch_target in cycle N+2.
- instr_valid, pc, instr and count change only on clk rising edges.
- rom_address changes only on clk rising edges.
- instr_ready is sampled on the rising edge.

## Structure
- Shared cpu package constants: XLEN=32, INSTR_BYTES=4, RESET_PC default.
- One sub-module: sync_fifo.
  - Generic parameterized width/depth FIFO with synchronous clear, push/pop, count and full/empty.
  - fetch_queue instantiates it with WIDTH=64.
  - fetch_queue keeps fetch_pc and the push/flush control.

## Test plan
- Reset, ROM word[i]=i, instr_ready=1:
  - instr_valid rises in cycle 1.
  - pc/instr sequence 0x0/0, 0x4/1, 0x8/2, … one per cycle.
  - count stays 1.
- Backpressure, instr_ready=0 from reset (DEPTH=4):
  - count goes 1,2,3,4; rom_address freezes at 0x10.
  - Then instr_ready=1 for one cycle: head 0x0 pops, 0x10 is pushed, count stays 4, rom_address becomes 0x14.
- Flush: with count=3, assert PCSrc=1 and branch_target=0x40.
  - Next cycle: count=0, instr_valid=0, pc=0, rom_address=0x40.
  - Following cycle: head pc=0x40.
- Flush with simultaneous pop (instr_valid=1, instr_ready=1, PCSrc=1, branch_target=0x80):
  - Pop and push discarded, count=0 next cycle.
  - First delivered pc is 0x80; no stale entry appears.
- Reset mid-operation with count=2 and fetch_pc=0x20:
  - Next cycle: instr_valid=0, count=0, rom_address=RESET_PC.
  - Sequence restarts at RESET_PC.
- Wrap-around: redirect to 0xFFFF_FFF8 with instr_ready=1.
  - Delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and the fetch-buffer entry layout used by the prefetch stage.
package fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
        return cur + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with clear, push/pop, occupancy count and full/empty flags.
module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_q == {CW{1'b0}});
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees the head slot, so a full FIFO may still accept a push alongside it.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, reads the ROM and buffers {pc, instr} for decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [XLEN-1:0]         rom_address,
    input  logic [XLEN-1:0]         rom_data,
    input  logic                    PCSrc,
    input  logic [XLEN-1:0]         branch_target,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         instr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    fetch_entry_t    wr_entry_s;
    fetch_entry_t    head_s;
    logic [2*XLEN-1:0] rdata_s;

    assign pop_s  = instr_valid & instr_ready;
    assign push_s = ~PCSrc & (~full_s | pop_s);

    assign wr_entry_s = '{pc: fetch_pc_q, instr: rom_data};
    assign head_s     = fetch_entry_t'(rdata_s);

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (PCSrc),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Fetch PC: a redirect wins over sequential advance; a stalled fetch holds.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (PCSrc) begin
            fetch_pc_d = branch_target;
        end else if (push_s) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign rom_address = fetch_pc_q;
    assign count       = count_s;
    assign instr_valid = ~empty_s;
    assign pc          = instr_valid ? head_s.pc    : {XLEN{1'b0}};
    assign instr       = instr_valid ? head_s.instr : {XLEN{1'b0}};

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table plus randomized run against a queue model.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  count;

    int tests;
    int fails;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .instr         (instr),
        .count         (count)
    );

    // ROM contents: word i holds i.
    assign rom_data = rom_address >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pcsrc;
        logic [31:0] bt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic [31:0] erom;
    } vec_t;

    vec_t vq[$];

    // Reference model: buffered PCs in order plus the fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mfpc;

    task automatic add(input logic rst, input logic pcsrc, input logic [31:0] bt, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [2:0] ecnt,
                       input logic [31:0] erom);
        vec_t v;
        v.rst = rst; v.pcsrc = pcsrc; v.bt = bt; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.erom = erom;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic pcsrc, input logic [31:0] bt,
                              input logic rdy);
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            mfpc = 32'h0000_0000;
        end else if (pcsrc) begin
            mq.delete();
            mfpc = bt;
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = (mq.size() < 4) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(mfpc);
                mfpc = mfpc + 32'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [31:0] mpc;
        mpc = (mq.size() > 0) ? mq[0] : 32'h0;
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, (mq.size() > 0)});
        chk({tag, ".pc"},    pc, mpc);
        chk({tag, ".instr"}, instr, (mq.size() > 0) ? (mpc >> 2) : 32'h0);
        chk({tag, ".count"}, {29'd0, count}, 32'(mq.size()));
        chk({tag, ".rom"},   rom_address, mfpc);
    endtask

    task automatic cycle(input logic rst, input logic pcsrc, input logic [31:0] bt, input logic rdy);
        reset = rst; PCSrc = pcsrc; branch_target = bt; instr_ready = rdy;
        @(posedge clk);
        #1;
        model_step(rst, pcsrc, bt, rdy);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; PCSrc = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
        mfpc = 32'h0;

        //   rst  src  target         rdy   valid pc             cnt    rom
        // streaming from reset
        add(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         3'd1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         3'd1, 32'h8);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         3'd1, 32'hC);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         3'd1, 32'h10);
        // backpressure to full, then one pop while full
        add(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd2, 32'h8);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd3, 32'hC);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd4, 32'h10);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd4, 32'h10);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         3'd4, 32'h14);
        // flush at count 3
        add(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd2, 32'h8);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3'd3, 32'hC);
        add(1'b0, 1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         3'd0, 32'h40);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        3'd1, 32'h44);
        // flush with a simultaneous pop
        add(1'b0, 1'b1, 32'h80,        1'b1, 1'b0, 32'h0,         3'd0, 32'h80);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h80,        3'd1, 32'h84);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h84,        3'd1, 32'h88);
        // reset mid-operation with count 2, fetch pc 0x20
        add(1'b0, 1'b1, 32'h18,        1'b0, 1'b0, 32'h0,         3'd0, 32'h18);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h18,        3'd1, 32'h1C);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h18,        3'd2, 32'h20);
        add(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         3'd1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         3'd1, 32'h8);
        // 32-bit wrap of the fetch pc
        add(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0,         3'd0, 32'hFFFF_FFF8);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 3'd1, 32'hFFFF_FFFC);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 3'd1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         3'd1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         3'd1, 32'h8);

        foreach (vq[i]) begin
            cycle(vq[i].rst, vq[i].pcsrc, vq[i].bt, vq[i].rdy);
            chk($sformatf("vec%0d.valid", i), {31'd0, instr_valid}, {31'd0, vq[i].ev});
            chk($sformatf("vec%0d.pc", i),    pc, vq[i].epc);
            chk($sformatf("vec%0d.instr", i), instr, vq[i].ev ? (vq[i].epc >> 2) : 32'h0);
            chk($sformatf("vec%0d.count", i), {29'd0, count}, {29'd0, vq[i].ecnt});
            chk($sformatf("vec%0d.rom", i),   rom_address, vq[i].erom);
        end

        // Randomized traffic: occasional resets, redirects (some unaligned), random backpressure.
        for (int n = 0; n < 600; n++) begin
            logic        r_rst;
            logic        r_src;
            logic [31:0] r_bt;
            logic        r_rdy;
            r_rst = ($urandom_range(0, 59) == 0);
            r_src = ($urandom_range(0, 11) == 0);
            r_bt  = $urandom;
            if ($urandom_range(0, 3) != 0) r_bt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r_bt = 32'hFFFF_FFF0;
            r_rdy = ($urandom_range(0, 99) < 55);
            cycle(r_rst, r_src, r_bt, r_rdy);
            model_check($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
